// File: rtl/clock_pkg.sv
// clock_pkg: shared types and defaults for the button conditioner.
//   rpt_state_t  - auto-repeat FSM states (IDLE, DELAY, REPEAT)
//   *_D          - default values for the debounce / repeat parameters
//   CNT_W        - width of every debounce / repeat counter
//   sat_inc      - saturating increment for CNT_W-bit counters
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  localparam int DB_CYCLES_D = 4;
  localparam int RPT_DELAY_D = 3;
  localparam int RPT_RATE_D  = 1;
  localparam int CNT_W       = 8;

  // Counters stop at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizer + debounce filter for one push-button.
//   clk, rst : clock and synchronous active-high reset
//   raw      : asynchronous, bouncing button input
//   level    : debounced level (registered)
//   rise     : one-cycle pulse, high in the cycle level first reads 1
// A raw edge reaches level 2 + DB_CYCLES cycles later: two synchronizer
// stages, then DB_CYCLES consecutive mismatching samples.
module btn_debounce
  import clock_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_D
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        // Any agreeing sample restarts the count, so bounces are ignored.
        cnt <= '0;
      end else if (sat_inc(cnt) >= DB_LAST) begin
        level <= sync2;
        rise  <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= sat_inc(cnt);
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounces the five clock-setting buttons and turns
// them into the mode levels, advance strobes and alarm enable used by the
// clock top level.
//   clk, rst          : clock, synchronous active-high reset
//   timeset_raw       : raw "set time" mode button
//   alarmset_raw      : raw "set alarm" mode button
//   minadv_raw        : raw minute-advance button
//   hrsadv_raw        : raw hour-advance button
//   alarmon_raw       : raw alarm on/off button
//   Timeset, Alarmset : debounced mode levels (Timeset wins, never both 1)
//   Minadv, Hrsadv    : one-cycle advance strobes with auto-repeat
//   Alarmon           : alarm enable, toggled by each accepted press
// Advance FSM: IDLE -> DELAY on an accepted press while a mode is active
// (strobe), DELAY -> REPEAT after RPT_DELAY cycles (strobe), then a strobe
// every RPT_RATE cycles. Releasing the button or leaving the mode returns
// to IDLE with no strobe.
module button_conditioner
  import clock_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_D,
  parameter int RPT_DELAY = RPT_DELAY_D,
  parameter int RPT_RATE  = RPT_RATE_D
) (
  input  logic clk,
  input  logic rst,
  input  logic timeset_raw,
  input  logic alarmset_raw,
  input  logic minadv_raw,
  input  logic hrsadv_raw,
  input  logic alarmon_raw,
  output logic Timeset,
  output logic Alarmset,
  output logic Minadv,
  output logic Hrsadv,
  output logic Alarmon
);

  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(RPT_DELAY);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(RPT_RATE);

  logic ts_level, as_level, am_level;
  logic ts_rise_unused, as_rise_unused, am_level_unused;
  logic am_rise;
  logic adv_level [2];
  logic adv_rise  [2];
  logic mode;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_timeset (
    .clk(clk), .rst(rst), .raw(timeset_raw),
    .level(ts_level), .rise(ts_rise_unused));

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_alarmset (
    .clk(clk), .rst(rst), .raw(alarmset_raw),
    .level(as_level), .rise(as_rise_unused));

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_minadv (
    .clk(clk), .rst(rst), .raw(minadv_raw),
    .level(adv_level[0]), .rise(adv_rise[0]));

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_hrsadv (
    .clk(clk), .rst(rst), .raw(hrsadv_raw),
    .level(adv_level[1]), .rise(adv_rise[1]));

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_alarmon (
    .clk(clk), .rst(rst), .raw(alarmon_raw),
    .level(am_level), .rise(am_rise));

  // Only the press edge of alarmon matters; its level is not used.
  assign am_level_unused = am_level;

  assign Timeset  = ts_level;
  assign Alarmset = as_level & ~ts_level;
  assign mode     = ts_level | as_level;

  always_ff @(posedge clk) begin
    if (rst) begin
      Alarmon <= 1'b0;
    end else if (am_rise) begin
      Alarmon <= ~Alarmon;
    end
  end

  // Index 0 = minutes, 1 = hours; the two FSMs share nothing but mode.
  rpt_state_t       rpt_state [2];
  logic [CNT_W-1:0] rpt_cnt   [2];
  logic             strobe    [2];

  for (genvar i = 0; i < 2; i++) begin : g_adv
    always_ff @(posedge clk) begin
      if (rst) begin
        rpt_state[i] <= IDLE;
        rpt_cnt[i]   <= '0;
        strobe[i]    <= 1'b0;
      end else begin
        strobe[i] <= 1'b0;
        if (!adv_level[i] || !mode) begin
          rpt_state[i] <= IDLE;
          rpt_cnt[i]   <= '0;
        end else begin
          case (rpt_state[i])
            IDLE: begin
              // Only a fresh press counts: a button held before the mode
              // came up never produces a rise here.
              if (adv_rise[i]) begin
                rpt_state[i] <= DELAY;
                rpt_cnt[i]   <= '0;
                strobe[i]    <= 1'b1;
              end
            end
            DELAY: begin
              if (sat_inc(rpt_cnt[i]) >= DELAY_LAST) begin
                rpt_state[i] <= REPEAT;
                rpt_cnt[i]   <= '0;
                strobe[i]    <= 1'b1;
              end else begin
                rpt_cnt[i] <= sat_inc(rpt_cnt[i]);
              end
            end
            REPEAT: begin
              if (sat_inc(rpt_cnt[i]) >= RATE_LAST) begin
                rpt_cnt[i] <= '0;
                strobe[i]  <= 1'b1;
              end else begin
                rpt_cnt[i] <= sat_inc(rpt_cnt[i]);
              end
            end
            default: begin
              rpt_state[i] <= IDLE;
              rpt_cnt[i]   <= '0;
            end
          endcase
        end
      end
    end
  end

  assign Minadv = strobe[0];
  assign Hrsadv = strobe[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner. Two instances share the stimulus: dut1 with
// default parameters, dut2 with RPT_RATE = 2. Expected strobe cycles are
// pushed when a button is pressed and popped when a strobe is seen.
module tb_button_conditioner;

  logic clk = 1'b0;
  logic rst;
  logic timeset_raw, alarmset_raw, minadv_raw, hrsadv_raw, alarmon_raw;
  logic ts1, as1, min1, hrs1, am1;
  logic ts2, as2, min2, hrs2, am2;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_hrs1   = 0;

  logic [31:0] exp_q_min1[$];
  logic [31:0] exp_q_hrs1[$];
  logic [31:0] exp_q_min2[$];
  logic [31:0] exp_q_hrs2[$];

  button_conditioner dut1 (
    .clk(clk), .rst(rst),
    .timeset_raw(timeset_raw), .alarmset_raw(alarmset_raw),
    .minadv_raw(minadv_raw), .hrsadv_raw(hrsadv_raw), .alarmon_raw(alarmon_raw),
    .Timeset(ts1), .Alarmset(as1), .Minadv(min1), .Hrsadv(hrs1), .Alarmon(am1));

  button_conditioner #(.DB_CYCLES(4), .RPT_DELAY(3), .RPT_RATE(2)) dut2 (
    .clk(clk), .rst(rst),
    .timeset_raw(timeset_raw), .alarmset_raw(alarmset_raw),
    .minadv_raw(minadv_raw), .hrsadv_raw(hrsadv_raw), .alarmon_raw(alarmon_raw),
    .Timeset(ts2), .Alarmset(as2), .Minadv(min2), .Hrsadv(hrs2), .Alarmon(am2));

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d required %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected strobes for a press driven at cycle press whose repeat ends
  // (button release or mode loss accepted) at cycle endc: debounce + FSM
  // register put the first strobe at press+7, the first repeat 3 later,
  // then one every RPT_RATE cycles.
  function automatic void push_adv(input bit hrs, input int press, input int endc);
    if (hrs) begin exp_q_hrs1.push_back(press + 7); exp_q_hrs2.push_back(press + 7); end
    else     begin exp_q_min1.push_back(press + 7); exp_q_min2.push_back(press + 7); end
    for (int c = press + 10; c <= endc; c += 1)
      if (hrs) exp_q_hrs1.push_back(c); else exp_q_min1.push_back(c);
    for (int c = press + 10; c <= endc; c += 2)
      if (hrs) exp_q_hrs2.push_back(c); else exp_q_min2.push_back(c);
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk_strobe(input int sel);
    int sz;
    logic [31:0] e;
    string tag;
    case (sel)
      0: begin sz = exp_q_min1.size(); tag = "minadv_dut1"; end
      1: begin sz = exp_q_hrs1.size(); tag = "hrsadv_dut1"; end
      2: begin sz = exp_q_min2.size(); tag = "minadv_dut2"; end
      default: begin sz = exp_q_hrs2.size(); tag = "hrsadv_dut2"; end
    endcase
    n_assert++;
    assert (sz != 0) else begin
      n_fail++;
      $error("FAIL %s: got strobe at cycle %0d required none", tag, cyc);
    end
    if (sz != 0) begin
      case (sel)
        0: e = exp_q_min1.pop_front();
        1: e = exp_q_hrs1.pop_front();
        2: e = exp_q_min2.pop_front();
        default: e = exp_q_hrs2.pop_front();
      endcase
      check({tag, "_cycle"}, cyc, e);
    end
  endtask

  always @(negedge clk) begin
    if (min1) chk_strobe(0);
    if (hrs1) begin chk_strobe(1); n_hrs1++; end
    if (min2) chk_strobe(2);
    if (hrs2) chk_strobe(3);
  end

  task automatic check_queues_empty(input string tag);
    check({tag, "_left_min1"}, exp_q_min1.size(), 0);
    check({tag, "_left_hrs1"}, exp_q_hrs1.size(), 0);
    check({tag, "_left_min2"}, exp_q_min2.size(), 0);
    check({tag, "_left_hrs2"}, exp_q_hrs2.size(), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int b, p, r, s, a, c;
    bit seq [9];
    seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    rst = 1'b1;
    timeset_raw = 1'b0; alarmset_raw = 1'b0; minadv_raw = 1'b0;
    hrsadv_raw = 1'b0; alarmon_raw = 1'b0;
    step(3);
    check("rst_timeset", ts1, 0);
    check("rst_alarmset", as1, 0);
    check("rst_minadv", min1, 0);
    check("rst_hrsadv", hrs1, 0);
    check("rst_alarmon", am1, 0);
    rst = 1'b0;
    step(2);

    // Hours button held before the mode rises never strobes; minutes
    // pressed inside the mode strobes and repeats until release.
    b = cyc;
    hrsadv_raw = 1'b1;
    goto(b + 3);
    timeset_raw = 1'b1;
    goto(b + 8);
    check("ts_before_latency", ts1, 0);
    goto(b + 9);
    check("ts_after_latency", ts1, 1);
    p = b + 11;
    goto(p);
    minadv_raw = 1'b1;
    push_adv(1'b0, p, p + 16);
    goto(p + 6);
    check("min_before_accept", min1, 0);
    r = p + 10;
    goto(r);
    minadv_raw = 1'b0; timeset_raw = 1'b0; hrsadv_raw = 1'b0;
    goto(r + 7);
    check("rel_timeset", ts1, 0);
    check("rel_minadv", min1, 0);
    check("rel_alarmon", am1, 0);
    goto(r + 10);
    check_queues_empty("held_then_press");

    // Clean timeset edge, then a bouncing alarmset.
    b = cyc;
    timeset_raw = 1'b1;
    goto(b + 5);
    check("clean_ts_5", ts1, 0);
    goto(b + 6);
    check("clean_ts_6", ts1, 1);
    timeset_raw = 1'b0;
    goto(b + 14);
    check("clean_ts_released", ts1, 0);
    s = cyc;
    for (int k = 0; k < 9; k++) begin
      alarmset_raw = seq[k];
      step(1);
    end
    goto(s + 9);
    check("bounce_as_early", as1, 0);
    goto(s + 10);
    check("bounce_as_accept", as1, 1);
    alarmset_raw = 1'b0;
    goto(s + 20);
    check("bounce_as_released", as1, 0);

    // Hours held 20 cycles in timeset mode: 1 + 17 repeat strobes on dut1.
    b = cyc;
    timeset_raw = 1'b1;
    goto(b + 8);
    p = cyc;
    n_hrs1 = 0;
    hrsadv_raw = 1'b1;
    push_adv(1'b1, p, p + 26);
    goto(p + 20);
    hrsadv_raw = 1'b0;
    goto(p + 30);
    check("hrs_strobe_count", n_hrs1, 18);
    check_queues_empty("hrs_hold");
    timeset_raw = 1'b0;
    goto(p + 40);

    // Timeset priority over Alarmset.
    b = cyc;
    timeset_raw = 1'b1; alarmset_raw = 1'b1;
    goto(b + 6);
    check("prio_ts", ts1, 1);
    check("prio_as_masked", as1, 0);
    goto(b + 10);
    timeset_raw = 1'b0;
    goto(b + 15);
    check("prio_as_still_masked", as1, 0);
    goto(b + 16);
    check("prio_as_after_release", as1, 1);
    check("prio_ts_released", ts1, 0);
    alarmset_raw = 1'b0;
    goto(b + 26);

    // Alarmset mode, minutes held, mode dropped mid-repeat.
    b = cyc;
    alarmset_raw = 1'b1;
    goto(b + 8);
    p = cyc;
    minadv_raw = 1'b1;
    push_adv(1'b0, p, p + 20);
    goto(p + 14);
    alarmset_raw = 1'b0;
    goto(p + 19);
    check("drop_as_before", as1, 1);
    goto(p + 20);
    check("drop_as_after", as1, 0);
    goto(p + 25);
    minadv_raw = 1'b0;
    goto(p + 35);
    check_queues_empty("mode_drop");

    // Alarmon toggles: two clean presses, third interrupted by reset.
    a = cyc;
    alarmon_raw = 1'b1;
    goto(a + 6);
    check("am_p1_before", am1, 0);
    goto(a + 7);
    check("am_p1_toggle", am1, 1);
    goto(a + 8);
    alarmon_raw = 1'b0;
    goto(a + 16);
    check("am_p1_release", am1, 1);
    alarmon_raw = 1'b1;
    goto(a + 22);
    check("am_p2_before", am1, 1);
    goto(a + 23);
    check("am_p2_toggle", am1, 0);
    goto(a + 24);
    alarmon_raw = 1'b0;
    goto(a + 32);
    check("am_p2_release", am1, 0);
    c = cyc;
    alarmon_raw = 1'b1;
    goto(c + 3);
    rst = 1'b1;
    goto(c + 5);
    check("am_p3_in_reset", am1, 0);
    rst = 1'b0;
    goto(c + 7);
    check("am_p3_aborted", am1, 0);
    goto(c + 11);
    check("am_p3_before_reaccept", am1, 0);
    goto(c + 12);
    check("am_p3_reaccept", am1, 1);
    alarmon_raw = 1'b0;
    goto(c + 22);
    check("am_p3_release", am1, 1);
    check_queues_empty("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
